// File: rtl/sprite_ram_write_ctrl.sv
// rtl/sprite_ram_write_ctrl.sv - write sequencer for sprite/colour-map RAM
// Turns single-write and fill commands into registered RAM write beats, optionally gated to blanking.
module sprite_ram_write_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  blank_en,
  input  logic                  in_blank,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  busy,
  output logic                  done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  beat_ok;

  assign beat_ok   = !blank_en || in_blank;
  assign cmd_ready = (state == IDLE);

  // ram_we/done for the coming cycle are decided at the edge that starts it,
  // so a beat is visible one cycle after beat_ok is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= '0;
      ram_we     <= 1'b0;
      ram_addr_w <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          done   <= 1'b0;
          if (cmd_valid) begin
            state      <= RUN;
            busy       <= 1'b1;
            ram_addr_w <= cmd_addr;
            ram_din    <= cmd_data;
            remaining  <= cmd_op ? cmd_len : '0;
            ram_we     <= beat_ok;
            done       <= beat_ok && (!cmd_op || (cmd_len == '0));
          end
        end
        RUN: begin
          if (ram_we && done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ram_we <= 1'b0;
            done   <= 1'b0;
          end else if (ram_we) begin
            ram_addr_w <= ram_addr_w + 1'b1;
            remaining  <= remaining - 1'b1;
            ram_we     <= beat_ok;
            done       <= beat_ok && (remaining == ADDR_WIDTH'(1));
          end else begin
            // stalled cycle: address, data and remaining hold
            ram_we <= beat_ok;
            done   <= beat_ok && (remaining == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sprite_ram_write_ctrl.md
# sprite_ram_write_ctrl

Write sequencer for a dual-address sprite/colour-map RAM: single-port write side (we, write address, data), with an independent registered read port owned by the pixel pipeline. Accepts write and fill commands from the MicroBlaze bus slot and turns them into per-cycle RAM write beats. Optionally holds all writes until the video blanking interval so sprites never tear mid-frame. Sits between the bus-slot register file and the player/ball sprite RAMs; the RAM read port is untouched.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address bits (RAM depth 2**ADDR_WIDTH)
- DATA_WIDTH, 3, colour-index bits per RAM word

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  1  0 = single write, 1 = fill
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  ADDR_WIDTH  fill word count minus 1; ignored for single write
- cmd_data  in  DATA_WIDTH  colour index to write
- blank_en  in  1  1 = write beats only when in_blank=1
- in_blank  in  1  video blanking indicator from the sync generator
- ram_we  out  1  RAM write enable
- ram_addr_w  out  ADDR_WIDTH  RAM write address
- ram_din  out  DATA_WIDTH  RAM write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on the final write beat of a command

## Operation
- FSM states: IDLE, RUN.
- IDLE: cmd_ready=1, busy=0. On cmd_valid, latch addr, data, remaining = (cmd_op ? cmd_len : 0); go RUN.
- RUN: cmd_ready=0, busy=1. Each cycle with beat_ok = (!blank_en || in_blank): drive ram_we=1 with current address/data. If remaining=0 the beat is final: done=1, next state IDLE. Otherwise address increments by 1, remaining decrements by 1.
- Stall: when beat_ok=0 in RUN, ram_we=0; address, remaining and data hold; no state change.
- Address arithmetic is modulo 2**ADDR_WIDTH: fill from 2**ADDR_WIDTH-2 with cmd_len=3 writes 2046, 2047, 0, 1 (ADDR_WIDTH=11).
- cmd_len = 2**ADDR_WIDTH-1 writes every word exactly once (full-RAM clear).
- cmd_* inputs are ignored outside the accepting IDLE cycle; changes during RUN have no effect.
- blank_en and in_blank are sampled every RUN cycle; toggling blank_en mid-fill takes effect on the next beat.
- Reset (asynchronous, at any time including mid-fill): state IDLE, ram_we=0, ram_addr_w=0, ram_din=0, busy=0, done=0, cmd_ready=1 after release; the in-progress fill is abandoned, with no further beats.

## Timing
- All outputs are registered except cmd_ready, which is decoded from state.
- Command accepted at edge N (cmd_valid & cmd_ready): first beat (ram_we=1) visible in cycle after N, earliest.
- Ungated fill of L words (cmd_len=L-1): ram_we high for L consecutive cycles; done coincident with the last; cmd_ready high the following cycle.
- Back-to-back single writes: one write per 2 cycles (accept, beat).
- Each gated cycle adds exactly one cycle to command duration; no beat is lost or duplicated.
- RAM read latency is unaffected. A read of an address written in the same cycle returns old data; the new data is returned from the next cycle.

## Test plan
- Reset mid-fill: start fill addr=0x100 len=63, assert reset_n=0 after 10 beats -> outputs 0 immediately; after release, 0x10A..0x13F unchanged, cmd_ready=1.
- Single write: op=0, addr=0x005, data=3 -> one ram_we pulse at 0x005 data 3 with done=1; readback of 0x005 = 3; busy back to 0 next cycle.
- Fill: op=1, addr=0x010, len=7, data=5 -> 8 consecutive beats 0x010..0x017, done on 0x017 only; 0x018 unchanged.
- Wrap-around: addr=0x7FE, len=3, data=2 -> beats at 0x7FE, 0x7FF, 0x000, 0x001.
- Blank gating: blank_en=1, fill len=9, in_blank toggling 3 cycles on / 5 off -> beats only while in_blank=1; exactly 10 beats, contiguous addresses, held address across gaps.
- Full clear: len=0x7FF, data=0 -> 2048 beats, every address read back 0, single done pulse; cmd_valid held high during RUN with other data -> ignored.
